// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store engine: RV32I width codes,
// FSM state encoding, alignment check and byte-lane helpers.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WRITE   = 2'd2,
    RESP    = 2'd3
  } stateT;

  // Illegal width codes are reported the same way as misaligned accesses.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offs);
    case (funct3)
      F3_B, F3_BU: is_misaligned = 1'b0;
      F3_H, F3_HU: is_misaligned = offs[0];
      F3_W:        is_misaligned = (offs != 2'b00);
      default:     is_misaligned = 1'b1;
    endcase
  endfunction

  // Bit position of the addressed lane inside the memory word.
  function automatic logic [4:0] laneShift(input logic [2:0] funct3, input logic [1:0] offs);
    case (funct3)
      F3_B, F3_BU: laneShift = {offs, 3'b000};
      F3_H, F3_HU: laneShift = {offs[1], 4'b0000};
      default:     laneShift = 5'd0;
    endcase
  endfunction

  // Bits of the memory word owned by the addressed lane.
  function automatic logic [31:0] laneMask(input logic [2:0] funct3, input logic [1:0] offs);
    case (funct3)
      F3_B, F3_BU: laneMask = 32'h0000_00FF << laneShift(funct3, offs);
      F3_H, F3_HU: laneMask = 32'h0000_FFFF << laneShift(funct3, offs);
      default:     laneMask = 32'hFFFF_FFFF;
    endcase
  endfunction

  // Replace the addressed lane of a word with the low bits of the store data.
  function automatic logic [31:0] storeMerge(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [2:0] funct3, input logic [1:0] offs);
    logic [31:0] mask;
    mask       = laneMask(funct3, offs);
    storeMerge = (word & ~mask) | ((wdata << laneShift(funct3, offs)) & mask);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake between the core control FSM and the unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_misalign
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_misalign
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Combinational load extraction: picks the addressed byte/half from a memory
// word and sign- or zero-extends it to 32 bits.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offs,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Shift the lane down to bit 0, then extend according to the width code.
  always_comb begin
    shifted = word >> laneShift(funct3, offs);
    // NOTE: result gets a default before the case so no path leaves it unassigned (no latch).
    result  = shifted;
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   result = {24'd0, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   result = {16'd0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator-side load/store engine. One byte-addressed request at a time is
// turned into word-addressed reads, writes or read-modify-write sequences.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus,
  output logic [31:0]        address,
  output logic [31:0]        writeData,
  output logic               memRead,
  output logic               memWrite,
  input  logic [31:0]        memData
);

  localparam int              CW     = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
  localparam logic [CW-1:0]   LAT_M1 = CW'(MEM_RD_LAT - 1);

  stateT        state;
  logic         reqWrite;
  logic [2:0]   reqFunct3;
  logic [1:0]   reqOffs;
  logic [31:0]  reqWdata;
  logic [CW-1:0] rdCount;
  logic         readyReg;
  logic         respValidReg;
  logic         respMisalignReg;
  logic [31:0]  respRdataReg;
  logic [31:0]  loadValue;
  logic [31:0]  mergedWord;

  load_align u_loadAlign (
    .word   (memData),
    .offs   (reqOffs),
    .funct3 (reqFunct3),
    .result (loadValue)
  );

  assign mergedWord        = storeMerge(memData, reqWdata, reqFunct3, reqOffs);

  assign bus.req_ready     = readyReg;
  assign bus.resp_valid    = respValidReg;
  assign bus.resp_rdata    = respRdataReg;
  assign bus.resp_misalign = respMisalignReg;

  // Control FSM with registered strobes plus the request/data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      readyReg        <= 1'b1;
      respValidReg    <= 1'b0;
      respMisalignReg <= 1'b0;
      respRdataReg    <= '0;
      address         <= '0;
      writeData       <= '0;
      memRead         <= 1'b0;
      memWrite        <= 1'b0;
      rdCount         <= '0;
      reqWrite        <= 1'b0;
      reqFunct3       <= '0;
      reqOffs         <= '0;
      reqWdata        <= '0;
    end else begin
      // NOTE: non-blocking assignments only, so every register sees the pre-edge values of its peers.
      respValidReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            readyReg  <= 1'b0;
            reqWrite  <= bus.req_write;
            reqFunct3 <= bus.req_funct3;
            reqOffs   <= bus.req_addr[1:0];
            reqWdata  <= bus.req_wdata;
            address   <= {2'b00, bus.req_addr[31:2]};
            if (is_misaligned(bus.req_funct3, bus.req_addr[1:0])) begin
              respValidReg    <= 1'b1;
              respMisalignReg <= 1'b1;
              respRdataReg    <= '0;
              state           <= RESP;
            end else if (bus.req_write && (bus.req_funct3 == F3_W)) begin
              writeData <= bus.req_wdata;
              memWrite  <= 1'b1;
              state     <= WRITE;
            end else begin
              memRead <= 1'b1;
              rdCount <= LAT_M1;
              state   <= RD_WAIT;
            end
          end
        end

        RD_WAIT: begin
          if (rdCount == '0) begin
            memRead <= 1'b0;
            if (reqWrite) begin
              writeData <= mergedWord;
              memWrite  <= 1'b1;
              state     <= WRITE;
            end else begin
              respRdataReg    <= loadValue;
              respMisalignReg <= 1'b0;
              respValidReg    <= 1'b1;
              state           <= RESP;
            end
          end else begin
            rdCount <= rdCount - CW'(1);
          end
        end

        WRITE: begin
          memWrite        <= 1'b0;
          respRdataReg    <= '0;
          respMisalignReg <= 1'b0;
          respValidReg    <= 1'b1;
          state           <= RESP;
        end

        RESP: begin
          readyReg <= 1'b1;
          state    <= IDLE;
        end

        default: begin
          readyReg <= 1'b1;
          memRead  <= 1'b0;
          memWrite <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side load/store engine for the multicycle RISC-V core: it takes one byte-addressed load or store request at a time and drives the word-addressed `memory` port (`address`, `writeData`, `memRead`, `memWrite`, `memData`). It sequences reads, writes and read-modify-write for sub-word stores. It handles alignment checks, byte-lane extraction and sign/zero extension. It sits between the core's control FSM and the unified instruction/data memory.

## Interface
- `MEM_RD_LAT`, 1: cycles `memRead` is held before `memData` is sampled (legal ≥1)
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `req_valid` in 1: request present
- `req_ready` out 1: high only in IDLE; request accepted on edge where `req_valid && req_ready`
- `req_write` in 1: 1 = store, 0 = load
- `req_funct3` in 3: RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU)
- `req_addr` in 32: byte address
- `req_wdata` in 32: store data (low bits used for B/H)
- `resp_valid` out 1: one-cycle completion pulse
- `resp_rdata` out 32: extended load data; 0 for stores/misaligned; held until next response
- `resp_misalign` out 1: valid with `resp_valid`; access suppressed
- `address` out 32: word index = `req_addr[31:2]` zero-extended
- `writeData` out 32: full word to memory
- `memRead` out 1, `memWrite` out 1: memory strobes
- `memData` in 32: memory read word

## Operation
- Request fields are latched on acceptance; inputs are ignored while busy.
- States: IDLE, RD_WAIT, WRITE, RESP.
- IDLE: `req_ready`=1, with all strobes 0. On acceptance the next state is:
  - RESP with `resp_misalign`=1 if the access is misaligned (H/HU with `addr[0]`=1; W with `addr[1:0]`≠0). Illegal funct3 (011, 110, 111) is also treated as misaligned.
  - RD_WAIT for loads and for B/H stores.
  - WRITE for W stores.
- RD_WAIT: `memRead`=1 and `address` held. A down-counter runs `MEM_RD_LAT` cycles. On the final edge `memData` is captured into the data register, then:
  - loads go to RESP;
  - sub-word stores go to WRITE.
- Load extract uses lane `addr[1:0]` (B) or half `addr[1]` (H). B/H sign-extend; BU/HU zero-extend.
- WRITE: `memWrite`=1 for exactly one cycle.
  - W store: `writeData`=`req_wdata`.
  - B/H store: `writeData` is the captured word with the addressed lane replaced by `req_wdata[7:0]` or `req_wdata[15:0]`.
  - Next state is RESP.
- RESP: `resp_valid`=1 for one cycle, then IDLE. A new request cannot be accepted in the RESP cycle.
- `memRead` and `memWrite` are never high in the same cycle.

## Timing
- Cycle 0 is the acceptance edge; the counts below are cycles after acceptance.
  - Load: `resp_valid` in cycle `MEM_RD_LAT`+1.
  - W store: WRITE in cycle 1, `resp_valid` in cycle 2.
  - B/H store: RD_WAIT in cycles 1..`MEM_RD_LAT`, WRITE in cycle `MEM_RD_LAT`+1, `resp_valid` in cycle `MEM_RD_LAT`+2.
  - Misaligned: `resp_valid` in cycle 1; `memRead`/`memWrite` stay 0 throughout.
- Reset values: state IDLE, `req_ready`=1 (after reset deasserts), all other outputs 0 (`resp_rdata`, `resp_misalign`, `address`, `writeData`, strobes, counter, latched fields).
- Reset mid-operation: the block returns to IDLE at the reset edge and no response is issued.
  - If the reset edge coincides with a WRITE cycle, memory sees `memWrite` at that edge and the write commits.
  - No partial read-modify-write is ever written after reset.
- `req_valid` held high continuously gives one accepted request per completed transaction, with ready low while busy.

## Structure
- Package `mem_access_pkg`:
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - state enum;
  - function `is_misaligned(funct3, addr[1:0])`.
- Sub-module `load_align`: combinational word + `addr[1:0]` + funct3 → extended 32-bit value. It is also reused for the store-merge mask, via a sibling function in the package.
- Target is a single always_ff FSM plus a datapath register, roughly 150–250 lines.

## Test plan
- `sw` addr 0x0C data 0xDEADBEEF:
  - cycle 1 has `memWrite`=1, `address`=3, `writeData`=0xDEADBEEF;
  - `resp_valid` in cycle 2 with `resp_rdata`=0.
- Loads of word 3 (= 0xDEADBEEF), with `MEM_RD_LAT`=1:
  - `lb` 0x0F → 0xFFFFFFDE;
  - `lbu` 0x0F → 0x000000DE;
  - `lh` 0x0E → 0xFFFFDEAD;
  - `lhu` 0x0C → 0x0000BEEF;
  - each with `memRead` high for 1 cycle and the response in cycle 2.
- `sb` addr 0x0D data 0x12 → read of word 3, then `memWrite` with `writeData`=0xDEAD12EF. `sh` addr 0x0E data 0x5678 → 0x5678BEEF.
- Misaligned: `lw` 0x0A, then `lh` 0x0B.
  - `resp_misalign`=1 in cycle 1, `resp_rdata`=0.
  - No strobes; memory word 2 unchanged.
- Reset: assert `reset` in cycle 1 of `lw` 0x14.
  - No `resp_valid`; `memRead`=0 after the edge; `req_ready`=1 after deassert.
  - Repeat with `MEM_RD_LAT`=3 and confirm `memRead` is held 3 cycles.
- Back-to-back: `req_valid` held for two `sw` (0x00 ← 1, 0x04 ← 2).
  - Exactly two acceptances, 3 cycles apart.
  - `req_ready` low in busy cycles; the memory holds 1 and 2.
